// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: three-stage pipelined floating-point adder/subtractor.
//   Stage 1 aligns operands and detects special values, stage 2 adds the extended
//   significands, stage 3 normalises, rounds to nearest even and packs the result.
//   Subnormal inputs and outputs are flushed to signed zero.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_valid / o_ready        operation handshake (o_ready low only while stalled)
//   i_operand_a/b, i_sub     operands, 0 = A+B, 1 = A-B
//   o_valid / i_ready        result handshake
//   o_result, o_flags        result word, {invalid, overflow, inexact}
//   i_tag / o_tag            sideband tag, present only when FP_ADDSUB_TAG_EN is defined
module fp_add_sub_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned TAG_W = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [EXP_W+MAN_W:0]   i_operand_a,
   input  logic [EXP_W+MAN_W:0]   i_operand_b,
   input  logic                   i_sub,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [EXP_W+MAN_W:0]   o_result,
   output logic [2:0]             o_flags
`ifdef FP_ADDSUB_TAG_EN
   ,
   input  logic [TAG_W-1:0]       i_tag,
   output logic [TAG_W-1:0]       o_tag
`endif
);

   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SigW  = MAN_W + 4;            // hidden, fraction, G, R, S
   localparam int unsigned ShMax = MAN_W + 3;
   localparam int unsigned LzW   = $clog2(SigW + 1);
   localparam int unsigned EW    = ((EXP_W > LzW) ? EXP_W : LzW) + 2;
   localparam int unsigned ExpMax = (1 << EXP_W) - 1;

   if (EXP_W < 3 || MAN_W < 2 || TAG_W < 1) begin : g_bad_params
      $fatal(1, "fp_add_sub_pipe: illegal parameters");
   end

   logic w_adv;

   // ---------------- Stage 1: classify, swap, align ----------------
   logic             w_sign_a, w_sign_b, w_a_zero, w_b_zero;
   logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_diff;
   logic [MAN_W-1:0] w_frac_a, w_frac_b;
   logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
   logic [W-2:0]     w_mag_a, w_mag_b, w_mag_l, w_mag_s;
   logic             w_swap, w_sign_l, w_sign_s;
   logic [SigW-1:0]  w_sig_l, w_sig_s, w_sig_s_al;
   logic [LzW-1:0]   w_sh;
   logic [2*SigW-1:0] w_al;
   logic             w_spec, w_spec_inv;
   logic [W-1:0]     w_spec_res, w_qnan;

   assign w_sign_a = i_operand_a[W-1];
   assign w_sign_b = i_operand_b[W-1] ^ i_sub;
   assign w_exp_a  = i_operand_a[W-2 -: EXP_W];
   assign w_exp_b  = i_operand_b[W-2 -: EXP_W];
   assign w_frac_a = i_operand_a[MAN_W-1:0];
   assign w_frac_b = i_operand_b[MAN_W-1:0];
   assign w_a_nan  = (&w_exp_a) & (|w_frac_a);
   assign w_b_nan  = (&w_exp_b) & (|w_frac_b);
   assign w_a_snan = w_a_nan & ~w_frac_a[MAN_W-1];
   assign w_b_snan = w_b_nan & ~w_frac_b[MAN_W-1];
   assign w_a_inf  = (&w_exp_a) & ~(|w_frac_a);
   assign w_b_inf  = (&w_exp_b) & ~(|w_frac_b);
   assign w_a_zero = ~(|w_exp_a);
   assign w_b_zero = ~(|w_exp_b);
   assign w_qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Subnormals become zero magnitude here, so they behave as signed zeros below.
   assign w_mag_a  = w_a_zero ? '0 : i_operand_a[W-2:0];
   assign w_mag_b  = w_b_zero ? '0 : i_operand_b[W-2:0];
   assign w_swap   = w_mag_b > w_mag_a;
   assign w_mag_l  = w_swap ? w_mag_b : w_mag_a;
   assign w_mag_s  = w_swap ? w_mag_a : w_mag_b;
   assign w_sign_l = w_swap ? w_sign_b : w_sign_a;
   assign w_sign_s = w_swap ? w_sign_a : w_sign_b;
   assign w_exp_l  = w_mag_l[W-2 -: EXP_W];
   assign w_exp_s  = w_mag_s[W-2 -: EXP_W];
   assign w_sig_l  = {|w_exp_l, w_mag_l[MAN_W-1:0], 3'b000};
   assign w_sig_s  = {|w_exp_s, w_mag_s[MAN_W-1:0], 3'b000};
   assign w_diff   = w_exp_l - w_exp_s;
   assign w_sh     = (32'(w_diff) > ShMax) ? LzW'(ShMax) : LzW'(w_diff);
   // Lower half of the double-width shift catches every bit shifted out for sticky.
   assign w_al       = {w_sig_s, {SigW{1'b0}}} >> w_sh;
   assign w_sig_s_al = {w_al[2*SigW-1:SigW+1], w_al[SigW] | (|w_al[SigW-1:0])};

   always_comb begin
      w_spec     = 1'b0;
      w_spec_inv = 1'b0;
      w_spec_res = '0;
      if (w_a_nan || w_b_nan) begin
         w_spec     = 1'b1;
         w_spec_inv = w_a_snan | w_b_snan;
         w_spec_res = w_qnan;
      end else if (w_a_inf && w_b_inf) begin
         w_spec = 1'b1;
         if (w_sign_a != w_sign_b) begin
            w_spec_inv = 1'b1;
            w_spec_res = w_qnan;
         end else begin
            w_spec_res = {w_sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
      end else if (w_a_inf || w_b_inf) begin
         w_spec     = 1'b1;
         w_spec_res = {w_a_inf ? w_sign_a : w_sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   logic             r1_valid, r1_spec, r1_spec_inv, r1_sign, r1_eff_sub, r1_zsign;
   logic [W-1:0]     r1_spec_res;
   logic [EXP_W-1:0] r1_exp;
   logic [SigW-1:0]  r1_sig_l, r1_sig_s;

   // ---------------- Stage 2: add ----------------
   logic [SigW:0]    w_sum;
   logic             r2_valid, r2_spec, r2_spec_inv, r2_sign, r2_zsign;
   logic [W-1:0]     r2_spec_res;
   logic [EXP_W-1:0] r2_exp;
   logic [SigW:0]    r2_sum;

   // |l| >= |s| so the subtraction never goes negative.
   assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_l} - {1'b0, r1_sig_s})
                             : ({1'b0, r1_sig_l} + {1'b0, r1_sig_s});

   // ---------------- Stage 3: normalise, round, pack ----------------
   logic [LzW-1:0]   w_lzc;
   logic [SigW-1:0]  w_norm;
   logic [EW-1:0]    w_exp_n, w_exp_r;
   logic             w_rnd_up, w_inexact;
   logic [MAN_W:0]   w_frac_r;
   logic [W-1:0]     w_result;
   logic [2:0]       w_flags;
   logic             r3_valid;
   logic [W-1:0]     r3_result;
   logic [2:0]       r3_flags;

   always_comb begin
      w_lzc = LzW'(SigW);
      for (int i = 0; i < int'(SigW); i++) begin
         if (r2_sum[i]) w_lzc = LzW'(int'(SigW) - 1 - i);
      end
   end

   always_comb begin
      if (r2_sum[SigW]) begin
         w_norm  = {r2_sum[SigW:2], r2_sum[1] | r2_sum[0]};
         w_exp_n = EW'(r2_exp) + EW'(1);
      end else begin
         w_norm  = r2_sum[SigW-1:0] << w_lzc;
         w_exp_n = EW'(r2_exp) - EW'(w_lzc);
      end
   end

   assign w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
   assign w_inexact = |w_norm[2:0];
   assign w_frac_r  = {1'b0, w_norm[SigW-2:3]} + (MAN_W+1)'(w_rnd_up);
   assign w_exp_r   = w_exp_n + EW'(w_frac_r[MAN_W]);

   always_comb begin
      w_result = '0;
      w_flags  = 3'b000;
      if (r2_spec) begin
         w_result = r2_spec_res;
         w_flags  = {r2_spec_inv, 2'b00};
      end else if (!w_norm[SigW-1]) begin
         // No leading one after normalisation means the sum was exactly zero.
         w_result = {r2_zsign, {(W-1){1'b0}}};
      end else if (w_exp_n[EW-1] || (w_exp_n == '0)) begin
         w_result = {r2_sign, {(W-1){1'b0}}};
         w_flags  = 3'b001;
      end else if (w_exp_r >= EW'(ExpMax)) begin
         w_result = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_flags  = 3'b011;
      end else begin
         w_result = {r2_sign, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
         w_flags  = {2'b00, w_inexact};
      end
   end

   // ---------------- Pipeline control and registers ----------------
   assign w_adv   = ~(r3_valid & ~i_ready);
   assign o_ready = w_adv;
   assign o_valid = r3_valid;
   assign o_result = r3_result;
   assign o_flags  = r3_flags;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r1_valid  <= 1'b0;
         r2_valid  <= 1'b0;
         r3_valid  <= 1'b0;
         r3_result <= '0;
         r3_flags  <= '0;
      end else if (w_adv) begin
         r1_valid <= i_valid;
         r2_valid <= r1_valid;
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_result <= w_result;
            r3_flags  <= w_flags;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_adv) begin
         r1_spec     <= w_spec;
         r1_spec_inv <= w_spec_inv;
         r1_spec_res <= w_spec_res;
         r1_sign     <= w_sign_l;
         r1_eff_sub  <= w_sign_l ^ w_sign_s;
         // Only two negative zeros can produce a negative exact zero.
         r1_zsign    <= w_sign_a & w_sign_b;
         r1_exp      <= w_exp_l;
         r1_sig_l    <= w_sig_l;
         r1_sig_s    <= w_sig_s_al;
         r2_spec     <= r1_spec;
         r2_spec_inv <= r1_spec_inv;
         r2_spec_res <= r1_spec_res;
         r2_sign     <= r1_sign;
         r2_zsign    <= r1_zsign;
         r2_exp      <= r1_exp;
         r2_sum      <= w_sum;
      end
   end

`ifdef FP_ADDSUB_TAG_EN
   logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r3_tag <= '0;
      end else if (w_adv && r2_valid) begin
         r3_tag <= r2_tag;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_adv) begin
         r1_tag <= i_tag;
         r2_tag <= r1_tag;
      end
   end

   assign o_tag = r3_tag;
`endif

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe with the default single-precision parameters.
module tb_fp_add_sub_pipe;

   localparam int unsigned TAG_W = 4;

   logic        clk = 1'b0;
   logic        i_rst_n, i_valid, o_ready, i_sub, o_valid, i_ready;
   logic [31:0] i_operand_a, i_operand_b, o_result;
   logic [2:0]  o_flags;
`ifdef FP_ADDSUB_TAG_EN
   logic [TAG_W-1:0] i_tag, o_tag;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W)) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_operand_a (i_operand_a),
      .i_operand_b (i_operand_b),
      .i_sub       (i_sub),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_flags     (o_flags)
`ifdef FP_ADDSUB_TAG_EN
      ,
      .i_tag       (i_tag),
      .o_tag       (o_tag)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; issues one op and checks the 3-cycle latency and result.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] exp_res, input logic [2:0] exp_fl);
      i_valid     = 1'b1;
      i_operand_a = a;
      i_operand_b = b;
      i_sub       = sub;
      i_ready     = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({tag, "_lat1"}, {31'd0, o_valid}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_lat2"}, {31'd0, o_valid}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, "_res"}, o_result, exp_res);
      check({tag, "_flags"}, {29'd0, o_flags}, {29'd0, exp_fl});
   endtask

   logic [31:0] bp_a [5];
   logic [31:0] bp_r [5];

   initial begin
      int issued, received, stalls;
      logic        held_valid;
      logic [31:0] held;
      logic        stalled;

      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sub = 1'b0;
      i_operand_a = '0; i_operand_b = '0;
`ifdef FP_ADDSUB_TAG_EN
      i_tag = '0;
`endif
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_result", o_result, 32'd0);
      check("rst_flags", {29'd0, o_flags}, 32'd0);
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      i_rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
      run_op("sub_1_1",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
      run_op("negz_m_posz", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
      run_op("negz_p_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
      run_op("one_p_mone", 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
      run_op("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
      run_op("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
      run_op("ovf",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
      run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
      run_op("inf_p_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
      run_op("one_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
      run_op("ninf_p_one", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
      run_op("qnan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
      run_op("snan",       32'h3F800000, 32'h7F800001, 1'b1, 32'h7FC00000, 3'b100);
      run_op("sub_1_2",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
      run_op("neg_add",    32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 3'b000);
      run_op("cancel",     32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 3'b000);
      run_op("underflow",  32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001);

      @(posedge clk); #1;
      check("drain", {31'd0, o_valid}, 32'd0);

      // Backpressure: 5 ops (k+1)+1, i_ready low on cycles 3..6.
      bp_a[0] = 32'h3F800000; bp_r[0] = 32'h40000000;
      bp_a[1] = 32'h40000000; bp_r[1] = 32'h40400000;
      bp_a[2] = 32'h40400000; bp_r[2] = 32'h40800000;
      bp_a[3] = 32'h40800000; bp_r[3] = 32'h40A00000;
      bp_a[4] = 32'h40A00000; bp_r[4] = 32'h40C00000;
      issued = 0; received = 0; stalls = 0; held_valid = 1'b0; held = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         i_ready     = !(cyc >= 3 && cyc <= 6);
         i_valid     = (issued < 5);
         i_operand_a = (issued < 5) ? bp_a[issued] : 32'h0;
         i_operand_b = 32'h3F800000;
         i_sub       = 1'b0;
`ifdef FP_ADDSUB_TAG_EN
         i_tag = TAG_W'(issued + 1);
`endif
         #1;
         stalled = o_valid & ~i_ready;
         if (stalled) begin
            stalls++;
            check("bp_ready_low", {31'd0, o_ready}, 32'd0);
            if (held_valid) check("bp_hold", o_result, held);
         end
         held_valid = stalled;
         held       = o_result;
         if (o_valid && i_ready) begin
            if (received < 5) begin
               check("bp_result", o_result, bp_r[received]);
`ifdef FP_ADDSUB_TAG_EN
               check("bp_tag", {28'd0, o_tag}, 32'(received + 1));
`endif
            end
            received++;
         end
         if (i_valid && o_ready) issued++;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check("bp_issued", 32'(issued), 32'd5);
      check("bp_received", 32'(received), 32'd5);
      check("bp_stalls", 32'(stalls), 32'd4);
      check("bp_idle", {31'd0, o_valid}, 32'd0);

      // Reset with three operations in flight.
      for (int k = 0; k < 3; k++) begin
         i_valid     = 1'b1;
         i_operand_a = bp_a[k];
         i_operand_b = 32'h3F800000;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
      i_rst_n = 1'b0;
      @(posedge clk); #1;
      i_rst_n = 1'b1;
      check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      check("mid_rst_result", o_result, 32'd0);
      check("mid_rst_flags", {29'd0, o_flags}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("post_rst_no_stale", {31'd0, o_valid}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_sub_pipe.md
Name: fp_add_sub_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the single-precision single-register add/sub block. Generalised in exponent and mantissa width, it adds a valid/ready handshake with backpressure, round-to-nearest-even, and full special-value handling with per-result status flags. It sits between operand-issue logic and the result writeback path of the FP datapath.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W
TAG_W, 4, sideband tag width (used only with FP_ADDSUB_TAG_EN)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  input operation valid
o_ready  out  1  block can accept an operation this cycle
i_operand_a  in  W  operand A
i_operand_b  in  W  operand B
i_sub  in  1  0 = A+B, 1 = A-B
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_result  out  W  result word
o_flags  out  3  {invalid, overflow, inexact}, aligned with o_result
i_tag / o_tag  in/out  TAG_W  only present with FP_ADDSUB_TAG_EN

Behaviour:
- Reset: all stage valids = 0, o_valid = 0, o_result = 0, o_flags = 0 on the first rising i_clk with i_rst_n = 0. The reset discards in-flight operations.
- Handshake: an input transfer occurs when i_valid & o_ready; an output transfer occurs when o_valid & i_ready.
- Stall: stall = o_valid & !i_ready. o_ready = !stall. The whole pipeline freezes while stalled.
- Output stability: o_result, o_flags and o_tag are held stable while o_valid=1 and i_ready=0.
- Latency and throughput: fixed 3 cycles from input transfer to o_valid with no stall; throughput 1 operation/cycle. Results are returned in issue order. Bubbles propagate as valid=0.
- Stage 1 (align):
  - Effective B sign = B.sign ^ i_sub.
  - Swap so that |A| >= |B| by comparing {exp, frac}.
  - Hidden bit = 1 if exp != 0.
  - Subnormal inputs are flushed to signed zero (FTZ).
  - exp_diff = expA - expB. Shift B's significand right by min(exp_diff, MAN_W+3), keeping guard, round and sticky bits; sticky = OR of all bits shifted out.
- Stage 2 (add): effective add/sub on (MAN_W+4)-bit extended significands plus a carry bit. Result sign = sign of the larger-magnitude operand.
- Stage 3 (normalise/round):
  - On carry-out: shift right by 1 and exponent +1.
  - Otherwise: leading-zero count, shift left, and subtract the count from the exponent.
  - Round to nearest even using G/R/S. Mantissa overflow from rounding increments the exponent.
  - inexact = G|R|S after normalisation.
- Exact zero result: +0, except (-0)+(-0) and (-0)-(+0), which give -0.
- Underflow: if the normalised exponent is <= 0, the result is signed zero with inexact=1 (FTZ, no subnormal output).
- Overflow: if the exponent reaches all-ones, the result is signed infinity with overflow=1 and inexact=1.
- Special values (detected in stage 1, bypass the arithmetic, same latency):
  - Any NaN input gives canonical qNaN (sign 0, exp all-ones, frac MSB 1), invalid=0 unless it is a signalling NaN (frac MSB 0), which sets invalid=1.
  - Inf - Inf (effective) gives canonical qNaN with invalid=1.
  - Inf op finite gives Inf with the operation's effective sign.
  - Inf + same-sign Inf gives that Inf.

Optional Feature:
FP_ADDSUB_TAG_EN:
- Defined: ports i_tag/o_tag exist. The tag is captured on input transfer and travels with the operation through all 3 stages, freezing on stall. o_tag resets to 0.
- Undefined: the tag ports and tag registers are absent; all other behaviour is identical.

Test Plan:
- Default params, A=0x3F800000, B=0x40000000, i_sub=0, i_ready=1 -> o_result=0x40400000, o_flags=000, o_valid exactly 3 cycles after transfer.
- A=0x3F800000, B=0x3F800000, i_sub=1 -> 0x00000000, flags 000. A=0x80000000, B=0x00000000, i_sub=1 -> 0x80000000.
- Rounding ties:
  - A=0x3F800000 + B=0x33800000 -> 0x3F800000, inexact=1 (tie to even).
  - A=0x3F800001 + B=0x33800000 -> 0x3F800002, inexact=1.
- Overflow and invalid:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 011.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, flags 100.
  - 0x7F800000 + 0x3F800000 -> 0x7F800000, flags 000.
- Backpressure: issue 5 back-to-back ops and hold i_ready=0 for 4 cycles mid-stream -> o_ready drops while stalled, o_result stays stable, all 5 results arrive in order with none lost or duplicated.
- Reset mid-operation: drive i_rst_n=0 for 1 cycle with 3 operations in flight -> o_valid=0 next cycle, no stale results afterwards. With FP_ADDSUB_TAG_EN, tags 1..5 return matched to their results.
